// File: rtl/exe_stage_pkg.sv
// Shared widths, divider state encodings and the decode-to-execute bus layout.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 154;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ES_FWD_BUS_WD   = 39;
    localparam int DIV_ITERS       = 32;

    // Divider FSM encodings; BUSY and DONE are one bit each so the state
    // can be rebuilt as {done, busy} outside the divider.
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // Field order matches the decode stage's concatenation, MSB first.
    typedef struct packed {
        logic [11:0] alu_op;     // one-hot: [0]add [1]sub [2]slt [3]sltu [4]and [5]nor
                                 //          [6]or [7]xor [8]sll [9]srl [10]sra [11]lui
        logic [3:0]  div_op;     // one-hot: [3]div.w [2]div.wu [1]mod.w [0]mod.wu
        logic        load_op;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        gr_we;
        logic        mem_we;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [31:0] rj_value;
        logic [31:0] rkd_value;
        logic [31:0] pc;
    } ds_to_es_t;

    // div.w and mod.w treat their operands as two's complement.
    function automatic logic is_signed_div(input logic [3:0] div_op);
        return div_op[3] | div_op[1];
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Pipeline-facing signals of the execute stage.
// Handshake: a transfer into ES happens on a rising edge where
// ds_to_es_valid && es_allowin; a transfer out to mem_stage happens on a
// rising edge where es_to_ms_valid && ms_allowin. Valid never depends on ready
// of the same side, and a presented instruction is held until it transfers.
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic                        ms_allowin;
    logic                        es_allowin;
    logic                        ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0]  ds_to_es_bus;
    logic                        es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus;
    logic [ES_FWD_BUS_WD-1:0]    es_fwd_bus;
    logic                        data_sram_en;
    logic [3:0]                  data_sram_we;
    logic [31:0]                 data_sram_addr;
    logic [31:0]                 data_sram_wdata;
    logic [1:0]                  div_state;   // debug view of the divider FSM

    modport master (
        input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
        output es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_bus,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
               div_state
    );

    modport slave (
        output ms_allowin, ds_to_es_valid, ds_to_es_bus,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_bus,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
               div_state
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU with a one-hot operation select.
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic [31:0] sra_res;

    assign sra_res = $signed(alu_src1) >>> alu_src2[4:0];

    // OR together the enabled operation; with a one-hot select exactly one term survives.
    always_comb begin
        alu_result = 32'd0;
        if (alu_op[0])  alu_result = alu_result | (alu_src1 + alu_src2);
        if (alu_op[1])  alu_result = alu_result | (alu_src1 - alu_src2);
        if (alu_op[2])  alu_result = alu_result | {31'd0, $signed(alu_src1) < $signed(alu_src2)};
        if (alu_op[3])  alu_result = alu_result | {31'd0, alu_src1 < alu_src2};
        if (alu_op[4])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[5])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[6])  alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[7])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[8])  alu_result = alu_result | (alu_src1 << alu_src2[4:0]);
        if (alu_op[9])  alu_result = alu_result | (alu_src1 >> alu_src2[4:0]);
        if (alu_op[10]) alu_result = alu_result | sra_res;
        if (alu_op[11]) alu_result = alu_result | alu_src2;
    end

endmodule

// File: rtl/exe_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign correction and divide-by-zero handling applied on the way out.
module div_iter
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [31:0] x_keep;
    logic        neg_q;
    logic        neg_r;
    logic        by_zero;

    logic [31:0] x_abs;
    logic [31:0] y_abs;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        fits;

    assign x_abs = (signed_op && x[31]) ? (~x + 32'd1) : x;
    assign y_abs = (signed_op && y[31]) ? (~y + 32'd1) : y;

    // Shift the next dividend bit into the partial remainder; a non-negative
    // difference means the divisor fits and the quotient bit is 1.
    assign trial = {rem, quo[31]};
    assign diff  = trial - {1'b0, dvs};
    assign fits  = ~diff[32];

    // FSM: IDLE -> BUSY on start, BUSY -> DONE after the last step, DONE -> IDLE on ack.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state <= DIV_BUSY;
                        cnt   <= 5'd0;
                    end
                end
                DIV_BUSY: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(DIV_ITERS - 1)) state <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (ack) state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    // Datapath: latch operands and sign info on start, then one restoring step per BUSY cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem     <= 32'd0;
            quo     <= 32'd0;
            dvs     <= 32'd0;
            x_keep  <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            by_zero <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            rem     <= 32'd0;
            quo     <= x_abs;
            dvs     <= y_abs;
            x_keep  <= x;
            neg_q   <= signed_op && (x[31] ^ y[31]);
            neg_r   <= signed_op && x[31];
            by_zero <= (y == 32'd0);
        end else if (state == DIV_BUSY) begin
            rem <= fits ? diff[31:0] : trial[31:0];
            quo <= {quo[30:0], fits};
        end
    end

    assign busy = (state == DIV_BUSY);
    assign done = (state == DIV_DONE);

    // Quotient is negative iff operand signs differ; remainder follows the dividend.
    assign q = by_zero ? 32'hFFFF_FFFF : (neg_q ? (~quo + 32'd1) : quo);
    assign r = by_zero ? x_keep        : (neg_r ? (~rem + 32'd1) : rem);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, iterative divider, data-SRAM request and forwarding bus.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    exe_stage_if.master pipe
);
    ds_to_es_t   es_r;
    logic        es_valid;
    logic        es_ready_go;
    logic        is_div;
    logic        div_busy;
    logic        div_done;
    logic        mem_go;
    logic        fwd_valid;
    logic        fwd_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_result;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] result;

    assign is_div           = |es_r.div_op;
    assign es_ready_go      = !is_div || div_done;
    assign pipe.es_allowin  = !es_valid || (es_ready_go && pipe.ms_allowin);
    assign pipe.es_to_ms_valid = es_valid && es_ready_go;

    // Stage occupancy: refilled (or emptied) whenever the stage can accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
        end else if (pipe.es_allowin) begin
            es_valid <= pipe.ds_to_es_valid;
        end
    end

    // Instruction register: only captures a real incoming instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_r <= '0;
        end else if (pipe.ds_to_es_valid && pipe.es_allowin) begin
            es_r <= pipe.ds_to_es_bus;
        end
    end

    assign src1 = es_r.src1_is_pc  ? es_r.pc  : es_r.rj_value;
    assign src2 = es_r.src2_is_imm ? es_r.imm : es_r.rkd_value;

    alu u_alu (
        .alu_op     (es_r.alu_op),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_result)
    );

    // The divider ignores start outside IDLE, so a finished division cannot
    // restart before it has been handed to mem_stage.
    div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (es_valid && is_div),
        .signed_op (is_signed_div(es_r.div_op)),
        .x         (src1),
        .y         (src2),
        .ack       (es_valid && pipe.ms_allowin),
        .busy      (div_busy),
        .done      (div_done),
        .q         (div_q),
        .r         (div_r)
    );

    assign pipe.div_state = {div_done, div_busy};

    assign result = (es_r.div_op[3] || es_r.div_op[2]) ? div_q :
                    (es_r.div_op[1] || es_r.div_op[0]) ? div_r : alu_result;

    assign pipe.es_to_ms_bus = {es_r.load_op, es_r.gr_we, es_r.dest, result, es_r.pc};

    // Loads are not ready for bypass until mem_stage returns the data.
    assign fwd_valid       = es_valid && es_r.gr_we && (es_r.dest != 5'd0);
    assign fwd_ready       = es_valid && es_ready_go && !es_r.load_op;
    assign pipe.es_fwd_bus = {fwd_valid, fwd_ready, es_r.dest, result};

    // Request only when mem_stage takes the instruction this cycle, so the
    // read data lines up with the instruction one cycle after handoff.
    assign mem_go               = es_valid && (es_r.load_op || es_r.mem_we) && pipe.ms_allowin;
    assign pipe.data_sram_en    = mem_go;
    assign pipe.data_sram_we    = {4{es_r.mem_we && mem_go}};
    assign pipe.data_sram_addr  = alu_result;
    assign pipe.data_sram_wdata = es_r.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with a cycle-level reference model.
module tb_exe_stage;

    logic clk;
    logic resetn;

    exe_stage_if pipe_bus ();

    exe_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .pipe   (pipe_bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [11:0] A_ADD = 12'h001, A_SUB = 12'h002, A_SLT = 12'h004, A_SLTU = 12'h008;
    localparam logic [11:0] A_AND = 12'h010, A_NOR = 12'h020, A_OR  = 12'h040, A_XOR  = 12'h080;
    localparam logic [11:0] A_SLL = 12'h100, A_SRL = 12'h200, A_SRA = 12'h400, A_LUI  = 12'h800;
    localparam logic [3:0]  D_DIVW = 4'b1000, D_DIVWU = 4'b0100, D_MODW = 4'b0010, D_MODWU = 4'b0001;

    int checks = 0;
    int errors = 0;

    logic [70:0] exp_q[$];

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [153:0] mk(input logic [11:0] aop, input logic [3:0] dop,
                                        input logic ld, input logic st, input logic s1pc,
                                        input logic s2imm, input logic gw, input logic [4:0] dst,
                                        input logic [31:0] imm, input logic [31:0] rj,
                                        input logic [31:0] rk, input logic [31:0] pc);
        return {aop, dop, ld, s1pc, s2imm, gw, st, dst, imm, rj, rk, pc};
    endfunction

    // Architectural result of one instruction, straight from the ISA definitions.
    function automatic logic [31:0] model_result(input logic [153:0] b);
        logic [11:0] aop;
        logic [3:0]  dop;
        logic [31:0] a;
        logic [31:0] c;
        logic [31:0] qq;
        logic [31:0] rr;
        aop = b[153:142];
        dop = b[141:138];
        a   = b[136] ? b[31:0]   : b[95:64];
        c   = b[135] ? b[127:96] : b[63:32];
        if (dop != 4'd0) begin
            if (c == 32'd0) begin
                qq = 32'hFFFF_FFFF;
                rr = a;
            end else if (dop[3] || dop[1]) begin
                if (a == 32'h8000_0000 && c == 32'hFFFF_FFFF) begin
                    qq = 32'h8000_0000;
                    rr = 32'd0;
                end else begin
                    qq = $signed(a) / $signed(c);
                    rr = $signed(a) % $signed(c);
                end
            end else begin
                qq = a / c;
                rr = a % c;
            end
            return (dop[3] || dop[2]) ? qq : rr;
        end
        case (aop)
            A_ADD:   return a + c;
            A_SUB:   return a - c;
            A_SLT:   return ($signed(a) < $signed(c)) ? 32'd1 : 32'd0;
            A_SLTU:  return (a < c) ? 32'd1 : 32'd0;
            A_AND:   return a & c;
            A_NOR:   return ~(a | c);
            A_OR:    return a | c;
            A_XOR:   return a ^ c;
            A_SLL:   return a << c[4:0];
            A_SRL:   return a >> c[4:0];
            A_SRA:   return 32'($signed(a) >>> c[4:0]);
            A_LUI:   return c;
            default: return 32'd0;
        endcase
    endfunction

    // reference model state: what sits in ES and for how many cycles
    bit          m_valid = 0;
    int          m_age   = 0;
    bit          m_div, m_load, m_store, m_gw;
    logic [4:0]  m_dest;
    logic [31:0] m_rk;

    // scoreboard / compare process, every falling edge
    always @(negedge clk) begin
        bit e_ready, e_go, e_allow, e_fv, e_men;
        if (!resetn) begin
            chk("rst_allowin",   71'(pipe_bus.es_allowin), 71'(1));
            chk("rst_to_ms_vld", 71'(pipe_bus.es_to_ms_valid), 71'(0));
            chk("rst_to_ms_bus", pipe_bus.es_to_ms_bus, 71'(0));
            chk("rst_fwd_bus",   71'(pipe_bus.es_fwd_bus), 71'(0));
            chk("rst_sram_en",   71'(pipe_bus.data_sram_en), 71'(0));
            chk("rst_sram_we",   71'(pipe_bus.data_sram_we), 71'(0));
            chk("rst_sram_addr", 71'(pipe_bus.data_sram_addr), 71'(0));
            chk("rst_sram_wdata",71'(pipe_bus.data_sram_wdata), 71'(0));
            chk("rst_div_state", 71'(pipe_bus.div_state), 71'(0));
            m_valid = 0;
            exp_q.delete();
        end else begin
            e_ready = !m_div || (m_age >= 33);
            e_go    = m_valid && e_ready;
            e_allow = !m_valid || (e_ready && pipe_bus.ms_allowin);
            chk("es_allowin",     71'(pipe_bus.es_allowin), 71'(e_allow));
            chk("es_to_ms_valid", 71'(pipe_bus.es_to_ms_valid), 71'(e_go));
            if (e_go) chk("es_to_ms_bus", pipe_bus.es_to_ms_bus, exp_q[0]);
            e_fv = m_valid && m_gw && (m_dest != 5'd0);
            chk("fwd_valid", 71'(pipe_bus.es_fwd_bus[38]), 71'(e_fv));
            chk("fwd_ready", 71'(pipe_bus.es_fwd_bus[37]), 71'(m_valid && e_ready && !m_load));
            if (e_fv && e_ready && !m_load)
                chk("fwd_dest_result", 71'(pipe_bus.es_fwd_bus[36:0]), 71'({m_dest, exp_q[0][63:32]}));
            e_men = m_valid && (m_load || m_store) && pipe_bus.ms_allowin;
            chk("sram_en", 71'(pipe_bus.data_sram_en), 71'(e_men));
            chk("sram_we", 71'(pipe_bus.data_sram_we), 71'({4{m_store && e_men}}));
            if (e_men) begin
                chk("sram_addr",  71'(pipe_bus.data_sram_addr), 71'(exp_q[0][63:32]));
                chk("sram_wdata", 71'(pipe_bus.data_sram_wdata), 71'(m_rk));
            end
            // advance the model across the coming rising edge
            if (e_go && pipe_bus.ms_allowin) void'(exp_q.pop_front());
            if (e_allow) begin
                m_valid = pipe_bus.ds_to_es_valid;
                if (pipe_bus.ds_to_es_valid) begin
                    m_div   = (pipe_bus.ds_to_es_bus[141:138] != 4'd0);
                    m_load  = pipe_bus.ds_to_es_bus[137];
                    m_gw    = pipe_bus.ds_to_es_bus[134];
                    m_store = pipe_bus.ds_to_es_bus[133];
                    m_dest  = pipe_bus.ds_to_es_bus[132:128];
                    m_rk    = pipe_bus.ds_to_es_bus[63:32];
                    m_age   = 0;
                    exp_q.push_back({m_load, m_gw, m_dest,
                                     model_result(pipe_bus.ds_to_es_bus),
                                     pipe_bus.ds_to_es_bus[31:0]});
                end
            end else begin
                m_age++;
            end
        end
    end

    // driver: present one instruction and hold it until accepted
    task automatic send(input string name, input logic [153:0] b);
        int n;
        bit ok;
        n = 0;
        ok = 0;
        pipe_bus.ds_to_es_valid = 1'b1;
        pipe_bus.ds_to_es_bus   = b;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (pipe_bus.es_allowin) ok = 1;
            else n++;
        end
        @(posedge clk);
        #1;
        pipe_bus.ds_to_es_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_accept actual=timeout required=accepted", name);
        end
    endtask

    // wait for the instruction in ES to be offered to mem_stage
    task automatic wait_handoff(input string name, input logic [31:0] req_res, input int req_lat,
                                output logic [70:0] bus_o, output logic [38:0] fwd_o);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        bus_o = '0;
        fwd_o = '0;
        while (!seen && n < 60) begin
            @(negedge clk);
            if (pipe_bus.es_to_ms_valid) begin
                seen  = 1;
                bus_o = pipe_bus.es_to_ms_bus;
                fwd_o = pipe_bus.es_fwd_bus;
            end else begin
                n++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_handoff actual=timeout required=valid", name);
        end else begin
            chk({name, "_latency"}, 71'(n), 71'(req_lat));
            chk(name, 71'(bus_o[63:32]), 71'(req_res));
        end
        @(posedge clk);
        #1;
    endtask

    // ALU table: op, rj, src2, use imm, src1 is pc, hand-computed result
    logic [11:0] t_op  [12] = '{A_SUB, A_SLT, A_SLTU, A_AND, A_NOR, A_OR,
                                A_XOR, A_SLL, A_SRL, A_SRA, A_LUI, A_ADD};
    logic [31:0] t_a   [12] = '{32'h0000000A, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                                32'h00000000, 32'h0F0F0000, 32'hFFFF0000, 32'h00000001,
                                32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000};
    logic [31:0] t_b   [12] = '{32'd3, 32'd1, 32'd1, 32'hFF00FF00, 32'h0, 32'h000000F0,
                                32'h0F0F0F0F, 32'd31, 32'd4, 32'd4, 32'h12345000, 32'h20};
    logic        t_imm [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic        t_pc  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [31:0] t_res [12] = '{32'h00000007, 32'h00000001, 32'h00000000, 32'hF000F000,
                                32'hFFFFFFFF, 32'h0F0F00F0, 32'hF0F00F0F, 32'h80000000,
                                32'h08000000, 32'hF8000000, 32'h12345000, 32'h1C000030};

    initial begin
        logic [70:0] hb;
        logic [38:0] hf;
        logic [153:0] ib;

        resetn = 1'b0;
        pipe_bus.ms_allowin     = 1'b1;
        pipe_bus.ds_to_es_valid = 1'b0;
        pipe_bus.ds_to_es_bus   = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // add.w 5 + 7
        send("add", mk(A_ADD, 4'd0, 0, 0, 0, 0, 1, 5'd1, 32'd0, 32'd5, 32'd7, 32'h1C000000));
        wait_handoff("add", 32'd12, 0, hb, hf);
        chk("add_gr_we", 71'(hb[69]), 71'(1));
        chk("add_load_op", 71'(hb[70]), 71'(0));

        // signed divide / modulo of a negative dividend
        send("divw", mk(12'd0, D_DIVW, 0, 0, 0, 0, 1, 5'd2, 32'd0, 32'hFFFFFFF9, 32'd2, 32'h1C000004));
        wait_handoff("divw", 32'hFFFFFFFD, 33, hb, hf);
        send("modw", mk(12'd0, D_MODW, 0, 0, 0, 0, 1, 5'd2, 32'd0, 32'hFFFFFFF9, 32'd2, 32'h1C000008));
        wait_handoff("modw", 32'hFFFFFFFF, 33, hb, hf);

        // divide by zero and the signed overflow case
        send("divwu0", mk(12'd0, D_DIVWU, 0, 0, 0, 0, 1, 5'd3, 32'd0, 32'd7, 32'd0, 32'h1C00000C));
        wait_handoff("divwu0", 32'hFFFFFFFF, 33, hb, hf);
        send("modwu0", mk(12'd0, D_MODWU, 0, 0, 0, 0, 1, 5'd3, 32'd0, 32'd7, 32'd0, 32'h1C000010));
        wait_handoff("modwu0", 32'd7, 33, hb, hf);
        send("modw0", mk(12'd0, D_MODW, 0, 0, 0, 0, 1, 5'd3, 32'd0, 32'hFFFFFFF9, 32'd0, 32'h1C000014));
        wait_handoff("modw0", 32'hFFFFFFF9, 33, hb, hf);
        send("divw0", mk(12'd0, D_DIVW, 0, 0, 0, 0, 1, 5'd3, 32'd0, 32'hFFFFFFF9, 32'd0, 32'h1C000018));
        wait_handoff("divw0", 32'hFFFFFFFF, 33, hb, hf);
        send("divw_ovf", mk(12'd0, D_DIVW, 0, 0, 0, 0, 1, 5'd3, 32'd0, 32'h80000000, 32'hFFFFFFFF, 32'h1C00001C));
        wait_handoff("divw_ovf", 32'h80000000, 33, hb, hf);
        send("modw_ovf", mk(12'd0, D_MODW, 0, 0, 0, 0, 1, 5'd3, 32'd0, 32'h80000000, 32'hFFFFFFFF, 32'h1C000020));
        wait_handoff("modw_ovf", 32'd0, 33, hb, hf);

        // st.w while mem_stage stalls for three cycles
        pipe_bus.ms_allowin = 1'b0;
        send("stw", mk(A_ADD, 4'd0, 0, 1, 0, 1, 0, 5'd0, 32'd4, 32'h100, 32'hA5A5A5A5, 32'h1C000024));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st_stall_en", 71'(pipe_bus.data_sram_en), 71'(0));
        end
        @(posedge clk);
        #1;
        pipe_bus.ms_allowin = 1'b1;
        @(negedge clk);
        chk("st_en",    71'(pipe_bus.data_sram_en), 71'(1));
        chk("st_we",    71'(pipe_bus.data_sram_we), 71'(4'hF));
        chk("st_addr",  71'(pipe_bus.data_sram_addr), 71'(32'h104));
        chk("st_wdata", 71'(pipe_bus.data_sram_wdata), 71'(32'hA5A5A5A5));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("st_en_after", 71'(pipe_bus.data_sram_en), 71'(0));
        @(posedge clk);
        #1;

        // ld.w is visible for bypass but not ready; dependent add follows
        send("ldw", mk(A_ADD, 4'd0, 1, 0, 0, 1, 1, 5'd4, 32'd8, 32'h200, 32'd0, 32'h1C000028));
        @(negedge clk);
        chk("ld_fwd_valid", 71'(pipe_bus.es_fwd_bus[38]), 71'(1));
        chk("ld_fwd_ready", 71'(pipe_bus.es_fwd_bus[37]), 71'(0));
        chk("ld_sram_addr", 71'(pipe_bus.data_sram_addr), 71'(32'h208));
        @(posedge clk);
        #1;
        send("dep_add", mk(A_ADD, 4'd0, 0, 0, 0, 0, 1, 5'd5, 32'd0, 32'h11, 32'h22, 32'h1C00002C));
        wait_handoff("dep_add", 32'h33, 0, hb, hf);

        // divider in flight holds fwd_ready low until done
        send("div_fwd", mk(12'd0, D_DIVWU, 0, 0, 0, 0, 1, 5'd6, 32'd0, 32'd1000, 32'd10, 32'h1C000030));
        repeat (5) @(negedge clk);
        chk("div_fwd_valid", 71'(pipe_bus.es_fwd_bus[38]), 71'(1));
        chk("div_fwd_ready", 71'(pipe_bus.es_fwd_bus[37]), 71'(0));
        chk("div_state_busy", 71'(pipe_bus.div_state), 71'(1));
        wait_handoff("div_fwd", 32'd100, 28, hb, hf);
        chk("div_fwd_ready_done", 71'(hf[37]), 71'(1));

        // reset in the middle of a division
        send("div_rst", mk(12'd0, D_DIVW, 0, 0, 0, 0, 1, 5'd7, 32'd0, 32'd100, 32'd7, 32'h1C000034));
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_state",   71'(pipe_bus.div_state), 71'(0));
        chk("mid_rst_allowin", 71'(pipe_bus.es_allowin), 71'(1));
        chk("mid_rst_valid",   71'(pipe_bus.es_to_ms_valid), 71'(0));
        chk("mid_rst_fwd",     71'(pipe_bus.es_fwd_bus[38]), 71'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        send("div_after_rst", mk(12'd0, D_DIVW, 0, 0, 0, 0, 1, 5'd7, 32'd0, 32'd100, 32'd7, 32'h1C000038));
        wait_handoff("div_after_rst", 32'd14, 33, hb, hf);

        // back-to-back divisions: second accepted on the first's handoff edge
        send("b2b_a", mk(12'd0, D_DIVWU, 0, 0, 0, 0, 1, 5'd8, 32'd0, 32'd1000, 32'd10, 32'h1C00003C));
        send("b2b_b", mk(12'd0, D_MODW, 0, 0, 0, 0, 1, 5'd9, 32'd0, 32'hFFFFFF9C, 32'd7, 32'h1C000040));
        wait_handoff("b2b_b", 32'hFFFFFFFE, 33, hb, hf);

        // ALU table back-to-back with mem_stage stalling now and then
        pipe_bus.ms_allowin = 1'b1;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk);
                    #1;
                    pipe_bus.ms_allowin = ($urandom_range(0, 3) != 0);
                end
                pipe_bus.ms_allowin = 1'b1;
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    ib = mk(t_op[i], 4'd0, 0, 0, t_pc[i], t_imm[i], 1, 5'(i + 10),
                            t_b[i], t_a[i], t_b[i], 32'h1C000010);
                    chk("model_pin", 71'(model_result(ib)), 71'(t_res[i]));
                    send("alu_tab", ib);
                end
            end
        join
        pipe_bus.ms_allowin = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain_empty", 71'(exp_q.size()), 71'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
